// File: rtl/riv_pchannel_if.sv
// P-channel controller bundle: transaction request/response side plus the per-channel device wires.
// Handshake: a request transfers on a rising clk edge where req_valid and req_ready are both high;
// req_pstate/req_mask must be stable while req_valid is high. done_valid is a one-cycle result pulse.
interface riv_pchannel_if #(
  parameter int NUM_CH   = 4,
  parameter int PSTATE_W = 4
);
  logic                       req_valid;
  logic                       req_ready;
  logic [PSTATE_W-1:0]        req_pstate;
  logic [NUM_CH-1:0]          req_mask;
  logic                       done_valid;
  logic [NUM_CH-1:0]          done_accept;
  logic [NUM_CH-1:0]          done_deny;
  logic [NUM_CH-1:0]          done_timeout;
  logic                       proto_err;
  logic [NUM_CH*PSTATE_W-1:0] pstate;
  logic [NUM_CH-1:0]          preq;
  logic [NUM_CH-1:0]          paccept;
  logic [NUM_CH-1:0]          pdeny;
  logic [NUM_CH-1:0]          pactive;
  logic [NUM_CH-1:0]          wake_req;

  modport master (
    input  req_valid, req_pstate, req_mask, paccept, pdeny, pactive,
    output req_ready, done_valid, done_accept, done_deny, done_timeout,
           proto_err, pstate, preq, wake_req
  );

  modport slave (
    output req_valid, req_pstate, req_mask, paccept, pdeny, pactive,
    input  req_ready, done_valid, done_accept, done_deny, done_timeout,
           proto_err, pstate, preq, wake_req
  );
endinterface

// File: rtl/riv_pchannel_controller.sv
// Multi-channel P-channel power controller: one PSTATE transition transaction at a time,
// with per-channel accept/deny/timeout bookkeeping, sticky protocol error and wake requests.
module riv_pchannel_controller #(
  parameter int                     NUM_CH      = 4,
  parameter int                     PSTATE_W    = 4,
  parameter logic [PSTATE_W-1:0]    PSTATE_RST  = '0,
  parameter int                     TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  riv_pchannel_if.master    bus,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_REQ     = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                             state;
  logic                               ready_q;
  logic [NUM_CH-1:0]                  mask_q;
  logic [PSTATE_W-1:0]                target_q;
  logic [NUM_CH-1:0][PSTATE_W-1:0]    committed;
  logic [NUM_CH-1:0][PSTATE_W-1:0]    pstate_q;
  logic [NUM_CH-1:0]                  preq_q;
  logic [NUM_CH-1:0]                  acc_q;
  logic [NUM_CH-1:0]                  den_q;
  logic [NUM_CH-1:0]                  tmo_q;
  logic [CNT_W-1:0]                   cnt;
  logic                               done_valid_q;
  logic [NUM_CH-1:0]                  done_accept_q;
  logic [NUM_CH-1:0]                  done_deny_q;
  logic [NUM_CH-1:0]                  done_timeout_q;
  logic                               proto_err_q;
  logic [NUM_CH-1:0]                  wake_q;

  logic [NUM_CH-1:0] resp;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] tmo_now;
  logic [NUM_CH-1:0] preq_nxt;
  logic [NUM_CH-1:0] in_window;
  logic [NUM_CH-1:0] nonrst;
  logic              timeout_hit;
  logic              proto_hit;

  // Only channels still holding PREQ can resolve; a response on the timeout cycle wins over the timeout.
  always_comb begin
    resp        = bus.paccept | bus.pdeny;
    hit         = (state == S_REQ) ? (preq_q & resp) : '0;
    timeout_hit = (state == S_REQ) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    tmo_now     = timeout_hit ? (preq_q & ~resp) : '0;
    preq_nxt    = timeout_hit ? '0 : (preq_q & ~resp);
    in_window   = ((state == S_REQ) || (state == S_RELEASE)) ? mask_q : '0;
    proto_hit   = (|(bus.paccept & bus.pdeny)) || (|(resp & ~in_window));
    nonrst      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      nonrst[c] = (committed[c] != PSTATE_RST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ready_q        <= 1'b1;
      mask_q         <= '0;
      target_q       <= '0;
      committed      <= {NUM_CH{PSTATE_RST}};
      pstate_q       <= {NUM_CH{PSTATE_RST}};
      preq_q         <= '0;
      acc_q          <= '0;
      den_q          <= '0;
      tmo_q          <= '0;
      cnt            <= '0;
      done_valid_q   <= 1'b0;
      done_accept_q  <= '0;
      done_deny_q    <= '0;
      done_timeout_q <= '0;
      proto_err_q    <= 1'b0;
      wake_q         <= '0;
    end else begin
      done_valid_q <= 1'b0;
      if (proto_hit) proto_err_q <= 1'b1;
      wake_q <= (state == S_IDLE) ? (bus.pactive & nonrst) : '0;

      case (state)
        S_IDLE: begin
          if (bus.req_valid && ready_q) begin
            mask_q   <= bus.req_mask;
            target_q <= bus.req_pstate;
            acc_q    <= '0;
            den_q    <= '0;
            tmo_q    <= '0;
            ready_q  <= 1'b0;
            if (bus.req_mask == '0) begin
              state          <= S_DONE;
              done_valid_q   <= 1'b1;
              done_accept_q  <= '0;
              done_deny_q    <= '0;
              done_timeout_q <= '0;
            end else begin
              // PSTATE is driven here so it is stable for the whole SETUP cycle before PREQ rises.
              state <= S_SETUP;
              for (int c = 0; c < NUM_CH; c++) begin
                if (bus.req_mask[c]) pstate_q[c] <= bus.req_pstate;
              end
            end
          end
        end

        S_SETUP: begin
          state  <= S_REQ;
          preq_q <= mask_q;
          cnt    <= '0;
        end

        S_REQ: begin
          preq_q <= preq_nxt;
          cnt    <= cnt + CNT_W'(1);
          acc_q  <= acc_q | (hit & bus.paccept & ~bus.pdeny);
          den_q  <= den_q | (hit & bus.pdeny);
          tmo_q  <= tmo_q | tmo_now;
          if (preq_nxt == '0) state <= S_RELEASE;
        end

        S_RELEASE: begin
          if ((resp & mask_q) == '0) begin
            state          <= S_DONE;
            done_valid_q   <= 1'b1;
            done_accept_q  <= acc_q;
            done_deny_q    <= den_q;
            done_timeout_q <= tmo_q;
            for (int c = 0; c < NUM_CH; c++) begin
              if (acc_q[c])       committed[c] <= target_q;
              else if (mask_q[c]) pstate_q[c]  <= committed[c];
            end
          end
        end

        S_DONE: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.done_valid   = done_valid_q;
  assign bus.done_accept  = done_accept_q;
  assign bus.done_deny    = done_deny_q;
  assign bus.done_timeout = done_timeout_q;
  assign bus.proto_err    = proto_err_q;
  assign bus.pstate       = pstate_q;
  assign bus.preq         = preq_q;
  assign bus.wake_req     = wake_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_riv_pchannel_controller.sv
// Bench for riv_pchannel_controller: per-channel device plans (kind, delay, hold) drive the P-channel
// wires; expected PREQ windows, done cycle, result masks and committed PSTATEs are computed arithmetically.
module tb_riv_pchannel_controller;
  localparam int NUM_CH   = 4;
  localparam int PSTATE_W = 4;
  localparam int TO       = 16;
  localparam logic [PSTATE_W-1:0] PRST = '0;
  localparam int K_ACC = 0, K_DENY = 1, K_BOTH = 2, K_SILENT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  riv_pchannel_if #(.NUM_CH(NUM_CH), .PSTATE_W(PSTATE_W)) pif ();

  riv_pchannel_controller #(
    .NUM_CH(NUM_CH), .PSTATE_W(PSTATE_W), .PSTATE_RST(PRST), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(pif.master), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  logic [PSTATE_W-1:0] committed_m [NUM_CH];
  logic                proto_m;
  logic [NUM_CH-1:0]   wake_exp;
  int plan_kind [NUM_CH];
  int plan_d    [NUM_CH];
  int plan_h    [NUM_CH];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH*PSTATE_W-1:0] committed_vec();
    logic [NUM_CH*PSTATE_W-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c*PSTATE_W +: PSTATE_W] = committed_m[c];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] nonrst_mask();
    logic [NUM_CH-1:0] m;
    m = '0;
    for (int c = 0; c < NUM_CH; c++) m[c] = (committed_m[c] != PRST);
    return m;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) committed_m[c] = PRST;
    proto_m  = 1'b0;
    wake_exp = '0;
  endtask

  task automatic idle_cycles(input int n, input bit fixed, input logic [NUM_CH-1:0] pa);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("idle_ready", pif.req_ready, 1);
      check_eq("idle_preq", pif.preq, 0);
      check_eq("idle_done", pif.done_valid, 0);
      check_eq("idle_pstate", pif.pstate, committed_vec());
      check_eq("wake_req", pif.wake_req, wake_exp);
      check_eq("proto_err", pif.proto_err, proto_m);
      pif.pactive = fixed ? pa : NUM_CH'($urandom);
      wake_exp    = pif.pactive & nonrst_mask();
    end
  endtask

  // Cycle 0 is the first cycle after the accepting edge; the first PREQ cycle is cycle 1.
  task automatic run_txn(input logic [PSTATE_W-1:0] target, input logic [NUM_CH-1:0] mask,
                         input int stray_ch);
    int last_req, last_high, first_low, dcyc, hi_end;
    logic [NUM_CH-1:0] exp_acc, exp_den, exp_tmo, exp_preq, resp;
    logic [NUM_CH*PSTATE_W-1:0] exp_ps;

    last_req = 1; last_high = 0;
    exp_acc = '0; exp_den = '0; exp_tmo = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        if (plan_kind[c] == K_SILENT) begin
          exp_tmo[c] = 1'b1;
          last_req = (TO > last_req) ? TO : last_req;
        end else begin
          if (plan_kind[c] == K_ACC) exp_acc[c] = 1'b1;
          else                       exp_den[c] = 1'b1;
          if (plan_kind[c] == K_BOTH) proto_m = 1'b1;
          last_req  = (1 + plan_d[c] > last_req) ? 1 + plan_d[c] : last_req;
          last_high = (1 + plan_d[c] + plan_h[c] > last_high) ? 1 + plan_d[c] + plan_h[c] : last_high;
        end
      end
    end
    if (stray_ch >= 0 && mask != '0) proto_m = 1'b1;
    first_low = (last_req + 1 > last_high + 1) ? last_req + 1 : last_high + 1;
    dcyc = (mask == '0) ? 0 : first_low + 1;

    @(negedge clk);
    check_eq("accept_ready", pif.req_ready, 1);
    check_eq("wake_req", pif.wake_req, wake_exp);
    pif.req_valid  = 1'b1;
    pif.req_pstate = target;
    pif.req_mask   = mask;
    pif.pactive    = NUM_CH'($urandom);
    wake_exp       = pif.pactive & nonrst_mask();

    for (int k = 0; k <= dcyc; k++) begin
      @(negedge clk);
      if (k == 0) pif.req_valid = 1'b0;
      if (k == dcyc) begin
        for (int c = 0; c < NUM_CH; c++) if (exp_acc[c]) committed_m[c] = target;
      end
      exp_preq = '0;
      exp_ps   = committed_vec();
      for (int c = 0; c < NUM_CH; c++) begin
        hi_end = (plan_kind[c] == K_SILENT) ? TO : 1 + plan_d[c];
        if (mask[c] && k >= 1 && k <= hi_end) exp_preq[c] = 1'b1;
        if (mask[c] && k < dcyc) exp_ps[c*PSTATE_W +: PSTATE_W] = target;
      end
      check_eq("preq", pif.preq, exp_preq);
      check_eq("pstate", pif.pstate, exp_ps);
      check_eq("done_valid", pif.done_valid, (k == dcyc));
      check_eq("busy_ready", pif.req_ready, 0);
      check_eq("wake_req", pif.wake_req, wake_exp);
      if (k == dcyc) begin
        check_eq("done_accept", pif.done_accept, exp_acc);
        check_eq("done_deny", pif.done_deny, exp_den);
        check_eq("done_timeout", pif.done_timeout, exp_tmo);
        check_eq("proto_err", pif.proto_err, proto_m);
      end
      resp = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        resp[c] = mask[c] && plan_kind[c] != K_SILENT &&
                  k >= 1 + plan_d[c] && k <= 1 + plan_d[c] + plan_h[c];
      end
      pif.paccept = '0;
      pif.pdeny   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        pif.paccept[c] = resp[c] && (plan_kind[c] == K_ACC || plan_kind[c] == K_BOTH);
        pif.pdeny[c]   = resp[c] && (plan_kind[c] == K_DENY || plan_kind[c] == K_BOTH);
      end
      if (stray_ch >= 0 && k == 1) pif.paccept[stray_ch] = 1'b1;
      pif.pactive = NUM_CH'($urandom);
      wake_exp    = '0;
    end
    pif.paccept = '0;
    pif.pdeny   = '0;
  endtask

  task automatic set_plan(input int c, input int kind, input int d, input int h);
    plan_kind[c] = kind; plan_d[c] = d; plan_h[c] = h;
  endtask

  task automatic plan_all(input int kind, input int d, input int h);
    for (int c = 0; c < NUM_CH; c++) set_plan(c, kind, d, h);
  endtask

  task automatic random_plan(input bit allow_both);
    int r;
    for (int c = 0; c < NUM_CH; c++) begin
      r = $urandom_range(0, 9);
      plan_kind[c] = (r < 5) ? K_ACC : (r < 7) ? K_DENY : (r < 8 && allow_both) ? K_BOTH :
                     (r < 8) ? K_ACC : K_SILENT;
      plan_d[c] = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 3);
      plan_h[c] = $urandom_range(0, 2);
    end
  endtask

  task automatic simple_reset();
    @(negedge clk);
    rst = 1'b1;
    pif.req_valid = 1'b0; pif.paccept = '0; pif.pdeny = '0; pif.pactive = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    pif.req_valid = 1'b0; pif.req_pstate = '0; pif.req_mask = '0;
    pif.paccept = '0; pif.pdeny = '0; pif.pactive = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_preq", pif.preq, 0);
    check_eq("rst_pstate", pif.pstate, committed_vec());
    check_eq("rst_done", pif.done_valid, 0);
    check_eq("rst_done_accept", pif.done_accept, 0);
    check_eq("rst_proto", pif.proto_err, 0);
    check_eq("rst_wake", pif.wake_req, 0);
    check_eq("rst_ready", pif.req_ready, 1);
    check_eq("rst_state", dbg_state, 0);
    rst = 1'b0;
    idle_cycles(2, 1'b1, '0);

    // Directed scenarios: accept, accept/deny mix, timeout, response on the timeout cycle, empty mask.
    plan_all(K_ACC, 2, 1);
    run_txn(4'd3, 4'b0101, -1);
    plan_all(K_ACC, 1, 1); set_plan(1, K_DENY, 1, 1);
    run_txn(4'd7, 4'b0011, -1);
    plan_all(K_ACC, 0, 1); set_plan(2, K_SILENT, 0, 0);
    run_txn(4'd5, 4'b0100, -1);
    plan_all(K_ACC, TO - 1, 0);
    run_txn(4'd6, 4'b1000, -1);
    run_txn(4'd9, 4'b0000, -1);
    plan_all(K_ACC, 1, 1);
    run_txn(4'd2, 4'b0001, -1);
    run_txn(4'd2, 4'b0001, -1);
    idle_cycles(1, 1'b1, 4'b0001);
    idle_cycles(2, 1'b1, 4'b0000);
    idle_cycles(1, 1'b1, 4'b0000);

    for (int n = 0; n < 40; n++) begin
      random_plan(1'b0);
      run_txn(PSTATE_W'($urandom), NUM_CH'($urandom), -1);
      idle_cycles($urandom_range(0, 3), 1'b0, '0);
    end

    // Reset in the middle of REQ: everything returns to reset values, no done pulse follows.
    plan_all(K_SILENT, 0, 0);
    @(negedge clk);
    pif.req_valid = 1'b1; pif.req_pstate = 4'd9; pif.req_mask = 4'b1111; pif.pactive = '0;
    @(negedge clk);
    pif.req_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_preq", pif.preq, 4'b1111);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check_eq("abort_preq", pif.preq, 0);
    check_eq("abort_pstate", pif.pstate, committed_vec());
    check_eq("abort_done", pif.done_valid, 0);
    rst = 1'b0;
    idle_cycles(4, 1'b1, '0);

    // Stray response on an unmasked channel.
    plan_all(K_ACC, 1, 0);
    run_txn(4'd4, 4'b0001, 2);
    idle_cycles(2, 1'b0, '0);
    simple_reset();
    idle_cycles(1, 1'b1, '0);

    // Simultaneous accept and deny counts as deny and latches proto_err until reset.
    plan_all(K_ACC, 1, 1); set_plan(1, K_BOTH, 1, 1);
    run_txn(4'd8, 4'b0011, -1);
    for (int n = 0; n < 15; n++) begin
      random_plan(1'b1);
      run_txn(PSTATE_W'($urandom), NUM_CH'($urandom), -1);
      idle_cycles($urandom_range(0, 2), 1'b0, '0);
    end

    // Response while idle.
    simple_reset();
    idle_cycles(1, 1'b1, '0);
    @(negedge clk);
    check_eq("idle_proto_before", pif.proto_err, 0);
    pif.paccept = 4'b0010;
    @(negedge clk);
    pif.paccept = '0;
    @(negedge clk);
    check_eq("idle_proto_after", pif.proto_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
